// File: rtl/uart_sys_ctrl.sv
// UART command-frame decoder driving the register file / ALU and returning results to the TX FIFO.
// Optional CMD_TIMEOUT_EN: abandons a partial frame after TIMEOUT_CYCLES idle cycles.
module uart_sys_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]     RF_RdData,
    input  logic                      RF_RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    input  logic                      FIFO_FULL,
    output logic                      RF_WrEn,
    output logic                      RF_RdEn,
    output logic [ADDR_WIDTH-1:0]     RF_Address,
    output logic [DATA_WIDTH-1:0]     RF_WrData,
    output logic                      ALU_EN,
    output logic [ALU_FUN_WIDTH-1:0]  ALU_FUN,
    output logic                      CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD
);
    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
        S_ALU_OPA, S_ALU_OPB, S_ALU_FUN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB
    } state_t;

    state_t                    state, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0]   res_q, res_d;
    logic                      two_q, two_d;
    logic                      wr_en_d, rd_en_d, alu_en_d, tx_vld_d, cg_d;
    logic [ADDR_WIDTH-1:0]     rf_addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_d, tx_data_d;
    logic [ALU_FUN_WIDTH-1:0]  fun_d;
    logic                      tmo_hit;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_frame;

    assign in_frame = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_OPA, S_ALU_OPB, S_ALU_FUN};
    assign tmo_hit  = in_frame && !RX_D_VLD && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                               tmo_cnt <= '0;
        else if (!in_frame || RX_D_VLD || tmo_hit) tmo_cnt <= '0;
        else                                    tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        res_d     = res_q;
        two_d     = two_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        tx_vld_d  = 1'b0;
        cg_d      = CLK_GATE_EN;
        rf_addr_d = RF_Address;
        wr_data_d = RF_WrData;
        fun_d     = ALU_FUN;
        tx_data_d = TX_P_DATA;
        case (state)
            S_IDLE: if (RX_D_VLD) begin
                if (RX_P_DATA == CMD_WR)       state_d = S_WR_ADDR;
                else if (RX_P_DATA == CMD_RD)  state_d = S_RD_ADDR;
                else if (RX_P_DATA == CMD_ALU) state_d = S_ALU_OPA;
                else if (RX_P_DATA == CMD_FUN) state_d = S_ALU_FUN;
            end
            S_WR_ADDR: if (RX_D_VLD) begin
                addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d = S_WR_DATA;
            end
            S_WR_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                rf_addr_d = addr_q;
                wr_data_d = RX_P_DATA;
                state_d   = S_IDLE;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
                rd_en_d   = 1'b1;
                rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: if (RF_RdData_Valid) begin
                res_d   = {{DATA_WIDTH{1'b0}}, RF_RdData};
                two_d   = 1'b0;
                state_d = S_TX_LSB;
            end
            // Operands land in fixed register slots 0 and 1 where the ALU reads them.
            S_ALU_OPA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                rf_addr_d = '0;
                wr_data_d = RX_P_DATA;
                state_d   = S_ALU_OPB;
            end
            S_ALU_OPB: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                rf_addr_d = ADDR_WIDTH'(1);
                wr_data_d = RX_P_DATA;
                state_d   = S_ALU_FUN;
            end
            S_ALU_FUN: if (RX_D_VLD) begin
                alu_en_d = 1'b1;
                cg_d     = 1'b1;
                fun_d    = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                state_d  = S_ALU_WAIT;
            end
            S_ALU_WAIT: begin
                cg_d = 1'b1;
                if (ALU_OUT_VALID) begin
                    res_d   = ALU_OUT;
                    two_d   = 1'b1;
                    cg_d    = 1'b0;
                    state_d = S_TX_LSB;
                end
            end
            S_TX_LSB: if (!FIFO_FULL) begin
                tx_vld_d  = 1'b1;
                tx_data_d = res_q[DATA_WIDTH-1:0];
                state_d   = two_q ? S_TX_MSB : S_IDLE;
            end
            // Skip one cycle after the LSB write so the FIFO strobe never stays high.
            S_TX_MSB: if (!FIFO_FULL && !TX_D_VLD) begin
                tx_vld_d  = 1'b1;
                tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) state_d = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            res_q       <= '0;
            two_q       <= 1'b0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            res_q       <= res_d;
            two_q       <= two_d;
            RF_WrEn     <= wr_en_d;
            RF_RdEn     <= rd_en_d;
            RF_Address  <= rf_addr_d;
            RF_WrData   <= wr_data_d;
            ALU_EN      <= alu_en_d;
            ALU_FUN     <= fun_d;
            CLK_GATE_EN <= cg_d;
            TX_P_DATA   <= tx_data_d;
            TX_D_VLD    <= tx_vld_d;
        end
    end
endmodule

// File: tb/tb_uart_sys_ctrl.sv
// Directed bench for uart_sys_ctrl: scoreboard of expected strobes, RF/ALU responders, protocol checks.
module tb_uart_sys_ctrl;
    localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ALU = 2'd2, K_TX = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic        CLK, RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [7:0]  RF_RdData;
    logic        RF_RdData_Valid;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VALID;
    logic        FIFO_FULL;
    logic        RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [3:0]  RF_Address, ALU_FUN;
    logic [7:0]  RF_WrData, TX_P_DATA;

    int checks = 0;
    int failures = 0;
    ev_t sb[$];
    logic [7:0]  rd_val = 8'h00;
    logic [15:0] alu_res = 16'h0;
    int          alu_lat = 3;
    logic        alu_abort = 1'b0;
    logic        ff_q = 1'b0;
    logic [3:0]  prev_stb = 4'b0;

    uart_sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID), .FIFO_FULL(FIFO_FULL),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [3:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        sb.push_back(e);
    endtask

    task automatic expect_ev(input string tag, input ev_t got);
        ev_t e;
        checks++;
        assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL %s unexpected obs=%0h exp=none", tag, got);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge CLK);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge CLK);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 32'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                      CLK_GATE_EN, TX_P_DATA, TX_D_VLD}), 32'd0);
    endtask

    always @(posedge CLK) ff_q <= FIFO_FULL;

    // Monitor: every strobe is matched against the scoreboard and the strobe rules.
    always @(negedge CLK) begin
        if (!RST) begin
            prev_stb <= 4'b0;
        end else begin
            if (RF_WrEn)  expect_ev("ev_wr",  {K_WR, RF_Address, 8'h00, RF_WrData});
            if (RF_RdEn)  expect_ev("ev_rd",  {K_RD, RF_Address, 16'h0});
            if (ALU_EN)   expect_ev("ev_alu", {K_ALU, 4'h0, 12'h0, ALU_FUN});
            if (TX_D_VLD) begin
                chk("tx_while_full", 32'(ff_q), 32'd0);
                expect_ev("ev_tx", {K_TX, 4'h0, 8'h00, TX_P_DATA});
            end
            if (RF_WrEn | RF_RdEn | ALU_EN | TX_D_VLD) begin
                chk("strobe_back2back", 32'(prev_stb & {RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD}), 32'd0);
                chk("wr_rd_overlap", 32'(RF_WrEn & RF_RdEn), 32'd0);
            end
            prev_stb <= {RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD};
        end
    end

    // Register-file read responder.
    always begin
        @(negedge CLK);
        if (RST && RF_RdEn) begin
            repeat (2) @(negedge CLK);
            RF_RdData       = rd_val;
            RF_RdData_Valid = 1'b1;
            @(negedge CLK);
            RF_RdData_Valid = 1'b0;
        end
    end

    // ALU responder; also watches the clock-gate enable across the operation.
    always begin
        @(negedge CLK);
        if (RST && ALU_EN) begin
            if (!alu_abort) chk("cg_at_en", 32'(CLK_GATE_EN), 32'd1);
            for (int i = 0; i < alu_lat; i++) begin
                @(negedge CLK);
                if (!alu_abort) chk("cg_wait", 32'(CLK_GATE_EN), 32'd1);
            end
            ALU_OUT       = alu_res;
            ALU_OUT_VALID = 1'b1;
            @(negedge CLK);
            ALU_OUT_VALID = 1'b0;
            if (!alu_abort) chk("cg_drop", 32'(CLK_GATE_EN), 32'd0);
        end
    end

    initial begin
        RST = 1'b0; RX_P_DATA = 8'h0; RX_D_VLD = 1'b0;
        RF_RdData = 8'h0; RF_RdData_Valid = 1'b0;
        ALU_OUT = 16'h0; ALU_OUT_VALID = 1'b0; FIFO_FULL = 1'b0;
        #1;
        chk_outs_zero("reset_outs");
        repeat (3) @(negedge CLK);
        RST = 1'b1;

        // Register write
        push(K_WR, 4'h5, 16'h003C);
        send_byte(8'hAA, 4); send_byte(8'h05, 4); send_byte(8'h3C, 4);
        drain("drain_write", 50);

        // Register read
        rd_val = 8'h3C;
        push(K_RD, 4'h5, 16'h0); push(K_TX, 4'h0, 16'h003C);
        send_byte(8'hBB, 4); send_byte(8'h05, 4);
        drain("drain_read", 50);

        // ALU with operands
        alu_res = 16'h000D; alu_lat = 3;
        push(K_WR, 4'h0, 16'h000A); push(K_WR, 4'h1, 16'h0003);
        push(K_ALU, 4'h0, 16'h0000);
        push(K_TX, 4'h0, 16'h000D); push(K_TX, 4'h0, 16'h0000);
        send_byte(8'hCC, 4); send_byte(8'h0A, 4); send_byte(8'h03, 4); send_byte(8'h00, 4);
        drain("drain_alu_ops", 60);

        // Back-pressure; a byte sent while results are pending must be dropped
        FIFO_FULL = 1'b1;
        alu_res = 16'hBEEF;
        push(K_ALU, 4'h0, 16'h0002);
        push(K_TX, 4'h0, 16'h00EF); push(K_TX, 4'h0, 16'h00BE);
        send_byte(8'hDD, 4); send_byte(8'h02, 4);
        repeat (4) @(negedge CLK);
        send_byte(8'hAA, 20);
        chk("bp_held", 32'(sb.size()), 32'd2);
        FIFO_FULL = 1'b0;
        drain("drain_bp", 40);

        // Unknown command ignored, then reset mid-frame
        send_byte(8'h55, 4);
        send_byte(8'hAA, 4); send_byte(8'h05, 2);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk_outs_zero("reset_midframe");
        @(negedge CLK);
        RST = 1'b1;
        push(K_WR, 4'h7, 16'h0011);
        send_byte(8'hAA, 4); send_byte(8'h07, 4); send_byte(8'h11, 4);
        drain("drain_after_rst", 50);

        // Reset while the ALU is busy drops the clock gate at once
        alu_abort = 1'b1; alu_lat = 30;
        push(K_ALU, 4'h0, 16'h0003);
        send_byte(8'hDD, 4); send_byte(8'h03, 4);
        chk("cg_busy", 32'(CLK_GATE_EN), 32'd1);
        RST = 1'b0;
        #1;
        chk_outs_zero("reset_alu_wait");
        @(negedge CLK);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        alu_abort = 1'b0; alu_lat = 3;
        chk("sb_after_abort", 32'(sb.size()), 32'd0);

        // Slow frame below any timeout still completes
        push(K_WR, 4'h7, 16'h005A);
        send_byte(8'hAA, 10); send_byte(8'h07, 10); send_byte(8'h5A, 4);
        drain("drain_slow", 50);

`ifdef CMD_TIMEOUT_EN
        // Stalled frame is abandoned; the next bytes decode as a fresh read
        rd_val = 8'h3C;
        send_byte(8'hAA, 20);
        push(K_RD, 4'h5, 16'h0); push(K_TX, 4'h0, 16'h003C);
        send_byte(8'hBB, 4); send_byte(8'h05, 4);
        drain("drain_timeout", 50);
`else
        // Without a timeout the frame waits indefinitely
        push(K_WR, 4'h5, 16'h003C);
        send_byte(8'hAA, 40); send_byte(8'h05, 4); send_byte(8'h3C, 4);
        drain("drain_no_timeout", 50);
`endif

        repeat (5) @(negedge CLK);
        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
